// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock enable, h/v counters,
// sync/display decode with a pix_ce-clocked delay line matching the pixel source latency.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 2,
    parameter int COORD_W    = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    output logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               display_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic [15:0]        frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PD = PIPE_DELAY;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 1 || PIPE_DELAY < 0 || PIPE_DELAY > 8 ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_param_check
        $error("vga_timing_gen: illegal parameter set");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             x_wrap;
    logic             y_wrap;
    logic             line_q;
    logic             frame_q;
    logic             act_raw;
    logic             hs_raw;
    logic             vs_raw;
    logic [2:0]       dly [0:PD];

    // rst_n gating keeps pix_ce low during reset even when CLK_DIV=1
    assign pix_ce = rst_n & enable & (div_cnt == DIV_LAST);
    assign x_wrap = (x == H_LAST);
    assign y_wrap = (y == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            frame_cnt <= '0;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            line_q  <= pix_ce & x_wrap;
            frame_q <= pix_ce & x_wrap & y_wrap;
            if (pix_ce) begin
                if (x_wrap) begin
                    x <= '0;
                    if (y_wrap) begin
                        y         <= '0;
                        frame_cnt <= frame_cnt + 16'd1;
                    end else begin
                        y <= y + COORD_W'(1);
                    end
                end else begin
                    x <= x + COORD_W'(1);
                end
            end
        end
    end

    assign act_raw = (x < H_ACT) && (y < V_ACT);
    assign hs_raw  = (x >= HS_START) && (x < HS_END);
    assign vs_raw  = (y >= VS_START) && (y < VS_END);

    // {act,hs,vs}; stage PD drives the outputs, so total latency is PD+1 ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= PD; i++) dly[i] <= '0;
        end else if (pix_ce) begin
            dly[0] <= {act_raw, hs_raw, vs_raw};
            for (int unsigned i = 1; i <= PD; i++) dly[i] <= dly[i-1];
        end
    end

    assign display_en  = dly[PD][2];
    assign hsync       = dly[PD][1] ? HS_POL : ~HS_POL;
    assign vsync       = dly[PD][0] ? VS_POL : ~VS_POL;
    assign vblank      = (y >= V_ACT);
    assign line_start  = line_q & enable;
    assign frame_start = frame_q & enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every clock against a
// tick-count raster model, plus directed checks with hand-computed values.
module tb_vga_timing_gen;

    typedef struct packed {
        int div; int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp; int hpol; int vpol; int pd;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst [3];
    logic        en  [3];
    logic        pce [3], hs [3], vs [3], de [3], ls [3], fs [3], vb [3];
    logic [11:0] xo  [3], yo [3];
    logic [15:0] fc  [3];

    longint mc [3];
    longint mn [3];
    bit     mls [3];
    bit     mfs [3];

    int chk = 0;
    int pass = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.CLK_DIV(4), .PIPE_DELAY(2)) u_a (
        .clk(clk), .rst_n(rst[0]), .enable(en[0]), .pix_ce(pce[0]), .hsync(hs[0]),
        .vsync(vs[0]), .display_en(de[0]), .x(xo[0]), .y(yo[0]), .line_start(ls[0]),
        .frame_start(fs[0]), .vblank(vb[0]), .frame_cnt(fc[0]));

    vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DELAY(2)) u_b (
        .clk(clk), .rst_n(rst[1]), .enable(en[1]), .pix_ce(pce[1]), .hsync(hs[1]),
        .vsync(vs[1]), .display_en(de[1]), .x(xo[1]), .y(yo[1]), .line_start(ls[1]),
        .frame_start(fs[1]), .vblank(vb[1]), .frame_cnt(fc[1]));

    vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1),
                     .PIPE_DELAY(0)) u_c (
        .clk(clk), .rst_n(rst[2]), .enable(en[2]), .pix_ce(pce[2]), .hsync(hs[2]),
        .vsync(vs[2]), .display_en(de[2]), .x(xo[2]), .y(yo[2]), .line_start(ls[2]),
        .frame_start(fs[2]), .vblank(vb[2]), .frame_cnt(fc[2]));

    function automatic cfg_t get_cfg(input int i);
        cfg_t c;
        case (i)
            0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2};
            1:       c = '{2, 16, 2, 3, 2, 12, 1, 2, 2, 0, 0, 2};
            default: c = '{1, 4, 1, 1, 1, 4, 1, 1, 1, 1, 0, 0};
        endcase
        return c;
    endfunction

    function automatic longint ht(input int i);
        cfg_t c = get_cfg(i);
        return c.ha + c.hfp + c.hsw + c.hbp;
    endfunction

    function automatic longint vt(input int i);
        cfg_t c = get_cfg(i);
        return c.va + c.vfp + c.vsw + c.vbp;
    endfunction

    function automatic bit m_tick(input int i);
        cfg_t c = get_cfg(i);
        return (rst[i] === 1'b1) && (en[i] === 1'b1) && (mc[i] % c.div == c.div - 1);
    endfunction

    // Model: mc = enabled clocks since reset, mn = pixel ticks since reset.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i] !== 1'b1) begin
                mc[i] <= 0; mn[i] <= 0; mls[i] <= 1'b0; mfs[i] <= 1'b0;
            end else begin
                if (en[i] === 1'b1) mc[i] <= mc[i] + 1;
                if (m_tick(i)) mn[i] <= mn[i] + 1;
                mls[i] <= m_tick(i) && ((mn[i] + 1) % ht(i) == 0);
                mfs[i] <= m_tick(i) && ((mn[i] + 1) % (ht(i) * vt(i)) == 0);
            end
        end
    end

    task automatic cmp(input int i);
        cfg_t        c = get_cfg(i);
        longint      n, pos, px, py;
        bit          a, hr, vr, up, lse, fse, pe;
        logic [46:0] got, exp;
        up  = (rst[i] === 1'b1);
        n   = up ? mn[i] : 0;
        lse = up && mls[i] && en[i];
        fse = up && mfs[i] && en[i];
        pe  = m_tick(i);
        a = 1'b0; hr = 1'b0; vr = 1'b0;
        if (n > c.pd) begin
            pos = n - c.pd - 1;
            px  = pos % ht(i);
            py  = (pos / ht(i)) % vt(i);
            a   = (px < c.ha) && (py < c.va);
            hr  = (px >= c.ha + c.hfp) && (px < c.ha + c.hfp + c.hsw);
            vr  = (py >= c.va + c.vfp) && (py < c.va + c.vfp + c.vsw);
        end
        exp = {pe, hr ? c.hpol[0] : !c.hpol[0], vr ? c.vpol[0] : !c.vpol[0], a, lse, fse,
               ((n / ht(i)) % vt(i)) >= c.va, 12'(n % ht(i)), 12'((n / ht(i)) % vt(i)),
               16'((n / (ht(i) * vt(i))) % 65536)};
        got = {pce[i], hs[i], vs[i], de[i], ls[i], fs[i], vb[i], xo[i], yo[i], fc[i]};
        chk++;
        if (got === exp) pass++;
        else $display("FAIL model_cmp[%0d] at %0t: got %h required %h (dut x=%0d y=%0d)",
                      i, $time, got, exp, xo[i], yo[i]);
    endtask

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) cmp(i);
    end

    task automatic check(input string name, input longint got, input longint req);
        chk++;
        if (got == req) pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, req);
    endtask

    initial begin
        int ticks, nclk, first_pce, de_t, hs_t, ls_t, lsx, lsy, bad;
        int k, hlow, vlow, dec, hfall, fsc, fc0;
        bit prev_hs;
        for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; en[i] = 1'b1; end
        repeat (3) @(negedge clk);
        check("rst_a_x", xo[0], 0);
        check("rst_a_hsync", hs[0], 1);
        check("rst_a_vsync", vs[0], 1);
        check("rst_a_de", de[0], 0);
        check("rst_a_pix_ce", pce[0], 0);
        check("rst_c_pix_ce", pce[2], 0);
        check("rst_c_hsync", hs[2], 0);
        @(posedge clk); #2;
        for (int i = 0; i < 3; i++) rst[i] = 1'b1;

        // Default timing: first tick, display/sync latency, first line wrap
        ticks = 0; nclk = 0; first_pce = -1; de_t = -1; hs_t = -1; ls_t = -1; lsx = -1; lsy = -1;
        while (ticks < 805 && nclk < 4000) begin
            @(negedge clk); nclk++;
            if (de[0] && de_t < 0) de_t = ticks;
            if (!hs[0] && hs_t < 0) hs_t = ticks;
            if (ls[0] && ls_t < 0) begin ls_t = ticks; lsx = xo[0]; lsy = yo[0]; end
            if (pce[0]) begin
                if (first_pce < 0) first_pce = nclk;
                ticks++;
            end
        end
        check("a_ticks_reached", ticks, 805);
        check("a_first_pix_ce_clk", first_pce, 4);
        check("a_de_rise_tick", de_t, 3);
        check("a_hsync_fall_tick", hs_t, 659);
        check("a_line_start_tick", ls_t, 800);
        check("a_line_start_x", lsx, 0);
        check("a_line_start_y", lsy, 1);

        // Freeze at x=100 for 37 clocks
        nclk = 0;
        while (xo[0] != 100 && nclk < 4000) begin @(negedge clk); nclk++; end
        check("a_reach_x100", xo[0], 100);
        @(posedge clk); #2; en[0] = 1'b0;
        bad = 0;
        repeat (37) begin
            @(negedge clk);
            if (xo[0] !== 12'd100 || pce[0] !== 1'b0) bad++;
        end
        check("a_hold_bad_cycles", bad, 0);
        @(posedge clk); #2; en[0] = 1'b1;
        nclk = 0;
        while (xo[0] == 100 && nclk < 20) begin @(negedge clk); nclk++; end
        check("a_resume_x", xo[0], 101);
        check("a_resume_clks", nclk, 4);

        // One full frame of the small raster, starting at an arbitrary tick
        nclk = 0;
        while (pce[1] !== 1'b1 && nclk < 10) begin @(negedge clk); nclk++; end
        check("b_window_start", pce[1], 1);
        k = 0; hlow = 0; vlow = 0; dec = 0; hfall = 0; fsc = 0; fc0 = fc[1]; prev_hs = 1'b0; nclk = 0;
        while (k < 392 && nclk < 1000) begin
            if (fs[1]) fsc++;
            if (pce[1]) begin
                if (k < 391) begin
                    if (!hs[1]) hlow++;
                    if (!vs[1]) vlow++;
                    if (de[1]) dec++;
                end
                if (k > 0 && prev_hs && !hs[1]) hfall++;
                prev_hs = hs[1];
                k++;
            end
            if (k < 392) begin @(negedge clk); nclk++; end
        end
        check("b_window_ticks", k, 392);
        check("b_hsync_low_ticks", hlow, 51);
        check("b_vsync_low_ticks", vlow, 46);
        check("b_de_high_ticks", dec, 192);
        check("b_hsync_pulses", hfall, 17);
        check("b_frame_starts", fsc, 1);
        check("b_frame_cnt_delta", (fc[1] - fc0) & 16'hFFFF, 1);

        // Asynchronous reset mid-frame
        nclk = 0;
        while (!(xo[1] == 10 && yo[1] == 5) && nclk < 1000) begin @(negedge clk); nclk++; end
        check("b_reach_x10_y5", {xo[1], yo[1]}, {12'd10, 12'd5});
        @(posedge clk); #3; rst[1] = 1'b0; #1;
        check("b_arst_x", xo[1], 0);
        check("b_arst_y", yo[1], 0);
        check("b_arst_hsync", hs[1], 1);
        check("b_arst_vsync", vs[1], 1);
        check("b_arst_de", de[1], 0);
        check("b_arst_frame_cnt", fc[1], 0);
        repeat (3) @(posedge clk); #2; rst[1] = 1'b1;

        // Tiny raster: exactly three frames after release
        @(posedge clk); #2; rst[2] = 1'b0;
        repeat (2) @(posedge clk); #2; rst[2] = 1'b1;
        repeat (147) @(posedge clk);
        @(negedge clk);
        check("c_frame_cnt_3", fc[2], 3);
        check("c_wrap_xy", {xo[2], yo[2]}, 0);
        check("c_frame_start", fs[2], 1);

        repeat (900) @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
